// File: rtl/jcr_boot_pkg.sv
// jcr_boot_pkg: register offsets, STATUS bit indices and FSM encodings for jcr_boot_ctrl
package jcr_boot_pkg;
    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_STATUS = 5'h04;
    localparam logic [4:0] OFF_ADDR   = 5'h08;
    localparam logic [4:0] OFF_DATA   = 5'h0C;
    localparam logic [4:0] OFF_CSUM   = 5'h10;
    localparam int ST_RUNNING = 0;
    localparam int ST_HOLDING = 1;
    localparam int ST_ERR     = 2;
    typedef enum logic [1:0] {BUS_IDLE, BUS_RD_WAIT, BUS_ACK} bus_state_t;
    typedef enum logic [1:0] {RUN_HALT, RUN_HOLD, RUN_RUN} run_state_t;
endpackage

// File: rtl/jcr_rst_seq.sv
// jcr_rst_seq: HALT/HOLD/RUN sequencer holding the CPU in reset for RST_CYCLES after run
module jcr_rst_seq
    import jcr_boot_pkg::*;
#(
    parameter int RST_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run_set,
    input  logic i_run_clr,
    output logic o_cpu_rst_n,
    output logic o_running,
    output logic o_holding
);
    localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    run_state_t r_state, w_next;
    logic [CW-1:0] r_cnt;

    // Counter reloads whenever not holding, so each HOLD entry starts a full count.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= RUN_HALT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == RUN_HOLD) ? r_cnt - 1'b1 : CW'(RST_CYCLES - 1);
        end
    end

    always_comb begin
        w_next = r_state;
        if (r_state == RUN_HALT)
            w_next = i_run_set ? RUN_HOLD : RUN_HALT;
        else if (i_run_clr)
            w_next = RUN_HALT;
        else if (r_state == RUN_HOLD && r_cnt == '0)
            w_next = RUN_RUN;
    end

    assign o_running   = (r_state == RUN_RUN);
    assign o_cpu_rst_n = (r_state == RUN_RUN);
    assign o_holding   = (r_state == RUN_HOLD);
endmodule

// File: rtl/jcr_boot_ctrl.sv
// jcr_boot_ctrl: Wishbone boot/run controller arbitrating instr_mem; JCR_BOOT_CHECKSUM_EN adds a write checksum at 0x10
module jcr_boot_ctrl
    import jcr_boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          RST_CYCLES = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [7:0]  cpu_pc_i,
    input  logic [7:0]  imem_rdata_i,
    output logic [7:0]  imem_addr_o,
    output logic [7:0]  imem_wdata_o,
    output logic        imem_we_o,
    output logic        cpu_rst_n_o,
    output logic        running_o
);
    bus_state_t r_bus, w_bus_next;
    logic        r_run, r_err, r_we, r_inc, r_rd_mem;
    logic [7:0]  r_addr, r_wdata;
    logic [31:0] r_dat, w_rdata, w_status, w_csum;
    logic [4:0]  w_off;
    logic        w_win, w_req, w_wr, w_data, w_data_ok, w_halt;
    logic        w_running, w_holding, w_cpu_rst_n, w_unused;

`ifdef JCR_BOOT_CHECKSUM_EN
    logic [7:0] r_csum;
    assign w_off  = wbs_adr_i[4:0];
    assign w_win  = (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    assign w_csum = {24'b0, r_csum};
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i)
            r_csum <= '0;
        else if (w_wr && w_off == OFF_ADDR)
            r_csum <= '0;
        else if (r_we)
            r_csum <= r_csum + r_wdata;
    end
`else
    assign w_off  = {1'b0, wbs_adr_i[3:0]};
    assign w_win  = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign w_csum = '0;
`endif

    assign w_unused  = &{1'b0, wbs_dat_i[31:8], wbs_sel_i[3:1], wbs_adr_i[4]};
    assign w_req     = (r_bus == BUS_IDLE) && wbs_stb_i && wbs_cyc_i && w_win;
    assign w_wr      = w_req && wbs_we_i && wbs_sel_i[0];
    assign w_halt    = !w_running && !w_holding;
    assign w_data    = w_req && (w_off == OFF_DATA);
    assign w_data_ok = w_data && w_halt;

    jcr_rst_seq #(.RST_CYCLES(RST_CYCLES)) u_rst_seq (
        .i_clk       (wb_clk_i),
        .i_rst_n     (wb_rst_n_i),
        .i_run_set   (w_wr && w_off == OFF_CTRL && wbs_dat_i[0]),
        .i_run_clr   (w_wr && w_off == OFF_CTRL && !wbs_dat_i[0]),
        .o_cpu_rst_n (w_cpu_rst_n),
        .o_running   (w_running),
        .o_holding   (w_holding)
    );

    always_comb begin
        w_status             = '0;
        w_status[ST_RUNNING] = w_running;
        w_status[ST_HOLDING] = w_holding;
        w_status[ST_ERR]     = r_err;
    end

    assign w_rdata = (w_off == OFF_CTRL)   ? {31'b0, r_run} :
                     (w_off == OFF_STATUS) ? w_status :
                     (w_off == OFF_ADDR)   ? {24'b0, r_addr} :
                     (w_off == OFF_CSUM)   ? w_csum : '0;

    // Halted DATA reads wait one cycle for the registered instr_mem output.
    always_comb begin
        w_bus_next = BUS_IDLE;
        if (r_bus == BUS_IDLE)
            w_bus_next = !w_req ? BUS_IDLE : (w_data_ok && !wbs_we_i) ? BUS_RD_WAIT : BUS_ACK;
        else if (r_bus == BUS_RD_WAIT)
            w_bus_next = wbs_cyc_i ? BUS_ACK : BUS_IDLE;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            r_bus    <= BUS_IDLE;
            r_run    <= 1'b0;
            r_err    <= 1'b0;
            r_we     <= 1'b0;
            r_inc    <= 1'b0;
            r_rd_mem <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_dat    <= '0;
        end else begin
            r_bus <= w_bus_next;
            r_we  <= w_wr && w_data_ok;
            if (w_req) begin
                r_dat    <= wbs_we_i ? '0 : w_rdata;
                r_rd_mem <= w_data_ok && !wbs_we_i;
                r_inc    <= w_data_ok && (!wbs_we_i || wbs_sel_i[0]);
                r_wdata  <= wbs_dat_i[7:0];
            end
            if (w_wr && w_off == OFF_CTRL)
                r_run <= wbs_dat_i[0];
            if (w_wr && w_off == OFF_ADDR)
                r_addr <= wbs_dat_i[7:0];
            else if (r_bus == BUS_ACK && r_inc)
                r_addr <= r_addr + 1'b1;
            if (w_data && !w_halt)
                r_err <= 1'b1;
            else if (w_wr && w_off == OFF_STATUS && wbs_dat_i[ST_ERR])
                r_err <= 1'b0;
        end
    end

    assign wbs_ack_o    = (r_bus == BUS_ACK);
    assign wbs_dat_o    = !wbs_ack_o ? '0 : r_rd_mem ? {24'b0, imem_rdata_i} : r_dat;
    assign imem_addr_o  = w_running ? cpu_pc_i : r_addr;
    assign imem_wdata_o = r_wdata;
    assign imem_we_o    = r_we && wb_rst_n_i;
    assign cpu_rst_n_o  = w_cpu_rst_n;
    assign running_o    = w_running;
endmodule

// File: tb/tb_jcr_boot_ctrl.sv
// tb_jcr_boot_ctrl: directed self-checking bench for jcr_boot_ctrl with a registered instr_mem model
module tb_jcr_boot_ctrl;
    localparam logic [31:0] B = 32'h3000_0000;

    logic        clk = 0, rst_n = 0;
    logic        stb = 0, cyc = 0, we = 0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr = 0, dat = 0;
    logic        ack;
    logic [31:0] dat_o;
    logic [7:0]  pc = 0, imem_rdata = 0, imem_addr, imem_wdata;
    logic        imem_we, cpu_rst_n, running;

    logic [7:0]  mem [256];
    logic [15:0] wq [$];
    int checks = 0, failures = 0;
    logic [31:0] rdat;
    int lat;

    always #5 clk = ~clk;

    jcr_boot_ctrl dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .cpu_pc_i(pc), .imem_rdata_i(imem_rdata), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
        .imem_we_o(imem_we), .cpu_rst_n_o(cpu_rst_n), .running_o(running)
    );

    always @(posedge clk) begin
        if (imem_we) mem[imem_addr] <= imem_wdata;
        imem_rdata <= mem[imem_addr];
    end

    always @(negedge clk) if (imem_we) wq.push_back({imem_addr, imem_wdata});

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output int l);
        @(negedge clk);
        stb = 1; cyc = 1; we = w; adr = a; dat = d; sel = 4'hF;
        l = -1; rd = '0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (ack) begin l = i; rd = dat_o; break; end
        end
        stb = 0; cyc = 0; we = 0;
    endtask

    task automatic reg_wr(input logic [31:0] off, input logic [31:0] d);
        logic [31:0] r;
        int l;
        wb_xfer(1'b1, B + off, d, r, l);
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (ack !== 1'b0 || dat_o !== 32'h0 || cpu_rst_n !== 1'b0 || running !== 1'b0 || imem_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: ack=%b dat=%h rst_n=%b run=%b we=%b expected all 0", ack, dat_o, cpu_rst_n, running, imem_we);
        end
        rst_n = 1;
        wb_xfer(1'b0, B + 32'h0, 0, rdat, lat);
        checks++;
        if (rdat !== 32'h0 || lat !== 1) begin failures++; $display("FAIL reset_ctrl: got %h lat %0d expected 0 lat 1", rdat, lat); end
        wb_xfer(1'b0, B + 32'h8, 0, rdat, lat);
        checks++;
        if (rdat !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h expected 0", rdat); end
        wb_xfer(1'b0, B + 32'h4, 0, rdat, lat);
        checks++;
        if (rdat !== 32'h0) begin failures++; $display("FAIL reset_status: got %h expected 0", rdat); end
    endtask

    task automatic test_load;
        logic [7:0] v [3] = '{8'h11, 8'h22, 8'h33};
        reg_wr(32'h8, 0);
        wq.delete();
        for (int i = 0; i < 3; i++) begin
            wb_xfer(1'b1, B + 32'hC, {24'h0, v[i]}, rdat, lat);
            checks++;
            if (lat !== 1) begin failures++; $display("FAIL load_ack_lat: got %0d expected 1", lat); end
        end
        @(negedge clk);
        checks++;
        if (wq.size() != 3) begin failures++; $display("FAIL load_pulses: got %0d expected 3", wq.size()); end
        else for (int i = 0; i < 3; i++) begin
            checks++;
            if (wq[i] !== {i[7:0], v[i]}) begin failures++; $display("FAIL load_write%0d: got %h expected %h", i, wq[i], {i[7:0], v[i]}); end
        end
        wb_xfer(1'b0, B + 32'h8, 0, rdat, lat);
        checks++;
        if (rdat !== 32'h3) begin failures++; $display("FAIL load_addr: got %h expected 3", rdat); end
`ifdef JCR_BOOT_CHECKSUM_EN
        wb_xfer(1'b0, B + 32'h10, 0, rdat, lat);
        checks++;
        if (rdat !== 32'h66) begin failures++; $display("FAIL checksum: got %h expected 66", rdat); end
`endif
    endtask

    task automatic test_wrap;
        reg_wr(32'h8, 32'hFF);
        wq.delete();
        wb_xfer(1'b1, B + 32'hC, 32'hAA, rdat, lat);
        @(negedge clk);
        checks++;
        if (wq.size() != 1 || wq[0] !== 16'hFFAA || mem[8'hFF] !== 8'hAA) begin
            failures++; $display("FAIL wrap_write: n=%0d mem[FF]=%h expected 1 write, AA", wq.size(), mem[8'hFF]);
        end
        wb_xfer(1'b0, B + 32'h8, 0, rdat, lat);
        checks++;
        if (rdat !== 32'h0) begin failures++; $display("FAIL wrap_addr: got %h expected 0", rdat); end
    endtask

    task automatic test_run;
        int n = 0;
        reg_wr(32'h0, 1);
        while (!cpu_rst_n && n < 10) begin n++; @(negedge clk); end
        checks++;
        if (n != 4) begin failures++; $display("FAIL run_rst_len: got %0d expected 4", n); end
        checks++;
        if (running !== 1'b1) begin failures++; $display("FAIL run_running: got %b expected 1", running); end
        pc = 8'h5A; #1;
        checks++;
        if (imem_addr !== 8'h5A) begin failures++; $display("FAIL run_pc_a: got %h expected 5A", imem_addr); end
        pc = 8'hC3; #1;
        checks++;
        if (imem_addr !== 8'hC3) begin failures++; $display("FAIL run_pc_b: got %h expected C3", imem_addr); end
        reg_wr(32'h0, 1);
        n = 0;
        repeat (3) begin if (!cpu_rst_n) n++; @(negedge clk); end
        checks++;
        if (n != 0) begin failures++; $display("FAIL run_no_repulse: got %0d low cycles expected 0", n); end
    endtask

    task automatic test_run_data;
        @(negedge clk);
        wq.delete();
        wb_xfer(1'b1, B + 32'hC, 32'h55, rdat, lat);
        @(negedge clk);
        checks++;
        if (lat !== 1 || wq.size() != 0) begin failures++; $display("FAIL run_data_write: lat=%0d writes=%0d expected 1, 0", lat, wq.size()); end
        wb_xfer(1'b0, B + 32'h4, 0, rdat, lat);
        checks++;
        if (rdat !== 32'h5) begin failures++; $display("FAIL run_status: got %h expected 5", rdat); end
        wb_xfer(1'b0, B + 32'hC, 0, rdat, lat);
        checks++;
        if (lat !== 1 || rdat !== 32'h0) begin failures++; $display("FAIL run_data_read: lat=%0d dat=%h expected 1, 0", lat, rdat); end
        wb_xfer(1'b0, B + 32'h8, 0, rdat, lat);
        checks++;
        if (rdat !== 32'h0) begin failures++; $display("FAIL run_addr_kept: got %h expected 0", rdat); end
    endtask

    task automatic test_read;
        int n = 0;
        reg_wr(32'h0, 0);
        checks++;
        if (running !== 1'b0 || cpu_rst_n !== 1'b0) begin failures++; $display("FAIL halt: run=%b rst_n=%b expected 0 0", running, cpu_rst_n); end
        reg_wr(32'h4, 32'h4);
        wb_xfer(1'b0, B + 32'h4, 0, rdat, lat);
        checks++;
        if (rdat !== 32'h0) begin failures++; $display("FAIL err_clear: got %h expected 0", rdat); end
        reg_wr(32'h8, 1);
        wb_xfer(1'b0, B + 32'hC, 0, rdat, lat);
        checks++;
        if (lat !== 2 || rdat !== 32'h22) begin failures++; $display("FAIL data_read: lat=%0d dat=%h expected 2, 22", lat, rdat); end
        checks++;
        if (ack !== 1'b1) begin failures++; $display("FAIL ack_high: got %b expected 1", ack); end
        @(negedge clk);
        checks++;
        if (ack !== 1'b0 || dat_o !== 32'h0) begin failures++; $display("FAIL ack_single: ack=%b dat=%h expected 0, 0", ack, dat_o); end
        @(negedge clk);
        stb = 1; cyc = 1; we = 0; adr = B + 32'hC;
        @(negedge clk);
        stb = 0; cyc = 0;
        repeat (3) begin @(negedge clk); if (ack) n++; end
        checks++;
        if (n != 0) begin failures++; $display("FAIL abort_no_ack: got %0d acks expected 0", n); end
        wb_xfer(1'b0, B + 32'h8, 0, rdat, lat);
        checks++;
        if (rdat !== 32'h2) begin failures++; $display("FAIL abort_addr: got %h expected 2", rdat); end
    endtask

    task automatic test_window;
        wb_xfer(1'b0, B + 32'h40, 0, rdat, lat);
        checks++;
        if (lat !== -1) begin failures++; $display("FAIL outside_window: lat=%0d expected no ack", lat); end
        wb_xfer(1'b0, B + 32'h1, 0, rdat, lat);
        checks++;
        if (lat !== 1 || rdat !== 32'h0) begin failures++; $display("FAIL unused_offset: lat=%0d dat=%h expected 1, 0", lat, rdat); end
    endtask

    task automatic test_reset_mid;
        reg_wr(32'h8, 32'h40);
        @(negedge clk);
        stb = 1; cyc = 1; we = 1; adr = B + 32'hC; dat = 32'h99;
        @(negedge clk);
        stb = 0; cyc = 0; we = 0;
        rst_n = 0;
        #1;
        checks++;
        if (imem_we !== 1'b0) begin failures++; $display("FAIL reset_mid_we: got %b expected 0", imem_we); end
        @(negedge clk);
        checks++;
        if (ack !== 1'b0 || mem[8'h40] !== 8'h00) begin failures++; $display("FAIL reset_mid: ack=%b mem[40]=%h expected 0, 00", ack, mem[8'h40]); end
        rst_n = 1;
        reg_wr(32'h0, 1);
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        checks++;
        if (cpu_rst_n !== 1'b0 || running !== 1'b0) begin failures++; $display("FAIL reset_hold: rst_n=%b run=%b expected 0 0", cpu_rst_n, running); end
        rst_n = 1;
        repeat (6) @(negedge clk);
        checks++;
        if (cpu_rst_n !== 1'b0 || running !== 1'b0) begin failures++; $display("FAIL reset_hold_stays: rst_n=%b run=%b expected 0 0", cpu_rst_n, running); end
        wb_xfer(1'b0, B + 32'h4, 0, rdat, lat);
        checks++;
        if (rdat !== 32'h0) begin failures++; $display("FAIL reset_hold_status: got %h expected 0", rdat); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset;
        test_load;
        test_wrap;
        test_run;
        test_run_data;
        test_read;
        test_window;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
